alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised successor to the single-cycle datapath ALU: registered arithmetic/logic/shift results plus an iterative unsigned multiply/divide unit with HI/LO registers. Sits in the EX stage; single-cycle ops return one cycle after acceptance, and MULTU/DIVU hold the pipeline through a `start`/`ready`/`done` handshake. The existing 4-bit operation encodings are preserved, so the ALU control decoder needs only additions.

## Interface
- `WIDTH`, 32: datapath width; even, ≥ 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request; accepted on an edge where `start && ready`.
- `op`  in  4  operation code.
- `a`, `b`  in  WIDTH each  operands.
- `shamt`  in  SHW  shift amount.
- `ready`  out  1  unit idle, will accept `start`.
- `done`  out  1  one-cycle pulse; `result`/`zero`/`ovf` valid.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  registered `(a == b)` of the accepted request.
- `ovf`  out  1  registered signed overflow (ADD/SUB only, else 0).
- `hi`, `lo`  out  WIDTH each  multiply/divide result registers.

## Operation
- Opcodes:
  - AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100.
  - SLL 0101 (`b << shamt`), SRL 0110 (`b >> shamt`).
  - LUI 0111 (`{b[WIDTH/2-1:0], WIDTH/2 zeros}`).
  - SRA 1000 (arithmetic `b >>> shamt`).
  - SLT 1001 (signed), SLTU 1010 (unsigned); result 1 or 0.
  - MULTU 1011, DIVU 1100.
  - MFHI 1101, MFLO 1110 (result = `hi` / `lo`).
  - 1111: undefined; result 0.
- All arithmetic is modulo 2^WIDTH.
- `ovf` for ADD: operands share a sign and the sign of the sum differs. For SUB: operand signs differ and the result sign differs from `a`.
- FSM states:
  - IDLE → MUL on accepted MULTU.
  - IDLE → DIV on accepted DIVU.
  - MUL/DIV → IDLE after WIDTH iterations.
  - All other ops stay in IDLE.
- `ready = (state == IDLE)`.
- MULTU: shift-add, one multiplier bit per cycle; `{hi,lo}` = full 2·WIDTH-bit unsigned product.
- DIVU: restoring, one quotient bit per cycle; `lo` = quotient, `hi` = remainder.
- Divide by zero: `lo` = all ones, `hi` = `a`; no flag.
- `result` for MULTU/DIVU is 0. `zero` and `ovf` are 0.
- Operands are captured at acceptance. Input changes while busy have no effect.
- `start` while `!ready` is ignored (not queued, not remembered).
- `hi`/`lo` change only on MULTU/DIVU completion or reset. MFHI issued in the cycle `done` pulses for a MULTU returns the new value.

## Timing
- Reset (`reset == 0` at an edge) gives:
  - `state` = IDLE, `ready` = 1, `done` = 0.
  - `result`, `zero`, `ovf`, `hi`, `lo`, iteration counter = 0.
- Reset mid-MUL/DIV aborts the operation. No `done` pulse follows.
- Single-cycle ops:
  - Accepted at edge k; `result`, `zero`, `ovf` updated at edge k.
  - `done` = 1 during cycle k→k+1.
  - `ready` stays 1, so back-to-back issue gives `done` high in consecutive cycles.
- MULTU/DIVU:
  - Accepted at edge k; `ready` = 0 from edge k.
  - Iterations run on edges k+1 … k+WIDTH.
  - `hi`/`lo` are written and `done` = 1 in cycle k+WIDTH → k+WIDTH+1. `ready` = 1 in that same cycle.
  - Latency is WIDTH+1 edges from acceptance to the `done` cycle.
- `done` is a register output and never high for more than one cycle per request.
- Outputs hold their values between requests.

## Structure
- Header `alu_defs.vh` holds the 4-bit opcode localparams and the FSM state encodings, shared with the ALU control decoder.
- Sub-module `muldiv_seq`, parameterised by `WIDTH`:
  - Holds the multiply/divide datapath: partial-product/remainder register, counter, operand latches.
  - Interface: `go`, `is_div`, `a`, `b` in; `fin`, `hi_out`, `lo_out` out.
- Top level contains the FSM, the combinational op mux, and the output registers.

## Test plan
- Reset with `start`=1, `op`=ADD → after the edge, all outputs 0, `ready`=1. No `done` while `reset`=0.
- WIDTH=32: ADD `a`=0x7FFFFFFF, `b`=1 → `done` next cycle, `result`=0x80000000, `ovf`=1, `zero`=0. SUB `a`=`b`=5 → `result`=0, `zero`=1, `ovf`=0.
- SRA `b`=0x80000000, `shamt`=4 → 0xF8000000. SLT `a`=-1, `b`=1 → 1. SLTU with the same operands → 0. LUI `b`=0x1234 → 0x12340000.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - `ready` low for 32 cycles; `done` at cycle 33 → `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - `start` pulses during the busy period are ignored.
  - MFHI next → 0xFFFFFFFE.
- DIVU 100 / 7 → `lo`=14, `hi`=2. DIVU 9 / 0 → `lo`=0xFFFFFFFF, `hi`=9.
- Reset asserted mid-DIVU (iteration 10) → no `done`, `hi`=`lo`=0, `ready`=1 next cycle. A new ADD is then accepted normally.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: opcode and FSM state encodings shared with the ALU control decoder
package alu_mdu_pkg;
  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_NOR   = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_LUI   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLT   = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_MULTU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_MFHI  = 4'b1101,
    OP_MFLO  = 4'b1110,
    OP_UNDEF = 4'b1111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  function automatic logic is_md(input logic [3:0] op);
    return op == OP_MULTU || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/alu_mdu_muldiv_seq.sv
// muldiv_seq: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle
module muldiv_seq
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH);
  logic             busy_q, div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, q_q, b_q, acc_d, q_d;
  logic [WIDTH:0]   sum, shifted, diff;
  // acc holds product-high / partial remainder; q holds multiplier / dividend shifting into quotient
  assign sum     = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
  assign shifted = {acc_q, q_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_q};
  always_comb begin
    acc_d = div_q ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    q_d   = div_q ? {q_q[WIDTH-2:0], !diff[WIDTH]} : {sum[0], q_q[WIDTH-1:1]};
  end
  assign fin    = busy_q && cnt_q == CW'(WIDTH - 1);
  assign hi_out = acc_d;
  assign lo_out = q_d;
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      b_q    <= '0;
    end else if (go) begin
      busy_q <= 1'b1;
      div_q  <= is_div;
      cnt_q  <= '0;
      acc_q  <= '0;
      q_q    <= a;
      b_q    <= b;
    end else if (busy_q) begin
      acc_q  <= acc_d;
      q_q    <= q_d;
      cnt_q  <= cnt_q + CW'(1);
      busy_q <= !fin;
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered single-cycle ALU plus iterative MULTU/DIVU with HI/LO registers
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_e           state_q, state_d;
  logic             accept, fin, done_q, zero_q, ovf_q, alu_ovf;
  logic [WIDTH-1:0] result_q, hi_q, lo_q, md_hi, md_lo, alu_res, sum, diff;

  assign accept = start && ready;
  assign sum    = a + b;
  assign diff   = a - b;

  muldiv_seq #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .reset  (reset),
    .go     (accept && is_md(op)),
    .is_div (op == OP_DIVU),
    .a      (a),
    .b      (b),
    .fin    (fin),
    .hi_out (md_hi),
    .lo_out (md_lo)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = fin ? S_IDLE : !accept ? state_q : op == OP_MULTU ? S_MUL : op == OP_DIVU ? S_DIV : S_IDLE;
  end

  always_comb begin
    ready = state_q == S_IDLE;
  end

  // MULTU/DIVU fall through to the default, so their registered result is 0
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_e'(op))
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1];
      end
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= (accept && !is_md(op)) || fin;
      if (accept) begin
        result_q <= alu_res;
        zero_q   <= a == b && !is_md(op);
        ovf_q    <= alu_ovf;
      end
      if (fin) begin
        hi_q <= md_hi;
        lo_q <= md_lo;
      end
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors checked every cycle against a behavioural model of alu_mdu
module tb_alu_mdu;
  localparam int W = 32;
  logic          clk = 1'b0;
  logic          reset, start, ready, done, zero, ovf;
  logic [3:0]    op;
  logic [W-1:0]  a, b, result, hi, lo;
  logic [4:0]    shamt;
  int            errors = 0, checks = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
    .ready(ready), .done(done), .result(result), .zero(zero), .ovf(ovf), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] alu_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] s, input logic [31:0] h, input logic [31:0] l);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint t  = 0;
    case (o)
      4'd0: return {1'b0, x & y};
      4'd1: return {1'b0, x | y};
      4'd2: return {1'b0, ~(x | y)};
      4'd3: begin t = sx + sy; return {t > 64'sd2147483647 || t < -64'sd2147483648, x + y}; end
      4'd4: begin t = sx - sy; return {t > 64'sd2147483647 || t < -64'sd2147483648, x - y}; end
      4'd5: return {1'b0, y << s};
      4'd6: return {1'b0, y >> s};
      4'd7: return {1'b0, y[15:0], 16'h0};
      4'd8: begin t = sy >>> s; return {1'b0, t[31:0]}; end
      4'd9: return {1'b0, 31'b0, sx < sy};
      4'd10: return {1'b0, 31'b0, x < y};
      4'd13: return {1'b0, h};
      4'd14: return {1'b0, l};
      default: return 33'b0;
    endcase
  endfunction

  int           m_busy = 0;
  bit           started = 0, m_done = 0, m_zero = 0, m_ovf = 0;
  logic [31:0]  m_res = 0, m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic [63:0]  prod;
  logic [32:0]  r;

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      m_busy = 0; m_done = 0; m_res = 0; m_zero = 0; m_ovf = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_done = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
      end else if (start) begin
        if (op == 4'd11 || op == 4'd12) begin
          m_busy = W; m_res = 0; m_zero = 0; m_ovf = 0;
          prod = {32'b0, a} * {32'b0, b};
          p_hi = op == 4'd11 ? prod[63:32] : (b == 0 ? a : a % b);
          p_lo = op == 4'd11 ? prod[31:0] : (b == 0 ? 32'hFFFFFFFF : a / b);
        end else begin
          r = alu_ref(op, a, b, shamt, m_hi, m_lo);
          m_res = r[31:0]; m_ovf = r[32]; m_zero = a == b; m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", ready, m_busy == 0);
      chk("done", done, m_done);
      chk("result", result, m_res);
      chk("zero", zero, m_zero);
      chk("ovf", ovf, m_ovf);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
    start = 1'b1; op = o; a = x; b = y; shamt = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk(nm, done, 1);
  endtask

  initial begin
    int cnt;
    reset = 1'b0; start = 1'b1; op = 4'd3; a = 32'h7FFFFFFF; b = 32'd1; shamt = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    issue(4'd3, 32'h7FFFFFFF, 32'd1, 5'd0);
    chk("add_done", done, 1);
    chk("add_res", result, 32'h80000000);
    chk("add_ovf", ovf, 1);
    chk("add_zero", zero, 0);
    chk("add_model", m_res, 32'h80000000);
    issue(4'd4, 32'd5, 32'd5, 5'd0);
    chk("sub_res", result, 0);
    chk("sub_zero", zero, 1);
    chk("sub_ovf", ovf, 0);
    issue(4'd8, 32'd0, 32'h80000000, 5'd4);
    chk("sra_res", result, 32'hF8000000);
    chk("sra_model", m_res, 32'hF8000000);
    issue(4'd9, 32'hFFFFFFFF, 32'd1, 5'd0);
    chk("slt_res", result, 1);
    issue(4'd10, 32'hFFFFFFFF, 32'd1, 5'd0);
    chk("sltu_res", result, 0);
    issue(4'd7, 32'd0, 32'h00001234, 5'd0);
    chk("lui_res", result, 32'h12340000);
    issue(4'd4, 32'h80000000, 32'd1, 5'd0);
    chk("subovf_res", result, 32'h7FFFFFFF);
    chk("subovf_ovf", ovf, 1);
    issue(4'd2, 32'd0, 32'd0, 5'd0);
    chk("nor_res", result, 32'hFFFFFFFF);
    issue(4'd5, 32'd0, 32'h00000003, 5'd31);
    chk("sll_res", result, 32'h80000000);
    issue(4'd6, 32'd0, 32'h80000000, 5'd31);
    chk("srl_res", result, 1);
    issue(4'd15, 32'd1, 32'd2, 5'd0);
    chk("undef_res", result, 0);
    issue(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
    chk("and_res", result, 32'hF000F000);
    issue(4'd1, 32'hF0F0F0F0, 32'h0F000000, 5'd0);
    chk("or_res", result, 32'hFFF0F0F0);
    issue(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    cnt = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!ready) cnt++;
      start = i == 5 || i == 12; op = 4'd3; a = 32'd1; b = 32'd1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("mul_busy_cycles", cnt, 32);
    chk("mul_done", done, 1);
    chk("mul_hi", hi, 32'hFFFFFFFE);
    chk("mul_lo", lo, 32'h00000001);
    chk("mul_model_hi", m_hi, 32'hFFFFFFFE);
    issue(4'd13, 32'd0, 32'd0, 5'd0);
    chk("mfhi_res", result, 32'hFFFFFFFE);
    issue(4'd14, 32'd0, 32'd0, 5'd0);
    chk("mflo_res", result, 1);
    issue(4'd12, 32'd100, 32'd7, 5'd0);
    wait_done("div_timeout");
    chk("div_lo", lo, 14);
    chk("div_hi", hi, 2);
    chk("div_result", result, 0);
    issue(4'd12, 32'd9, 32'd0, 5'd0);
    wait_done("div0_timeout");
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 9);
    issue(4'd12, 32'd1000, 32'd3, 5'd0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (40) @(negedge clk);
    issue(4'd3, 32'd2, 32'd3, 5'd0);
    chk("post_abort_add", result, 5);
    chk("post_abort_done", done, 1);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
